// File: rtl/intersection_pkg.sv
// Shared encodings for the intersection phase scheduler: light states, FSM states
// and the vehicle rotation order.
package intersection_pkg;

  typedef enum logic [2:0] {
    SUD     = 3'b000,
    EST     = 3'b001,
    VEST    = 3'b010,
    NORD    = 3'b011,
    PIETONI = 3'b100,
    SERVICE = 3'b111
  } light_t;

  typedef enum logic [1:0] {
    ISSUE      = 2'd0,
    WAIT_READY = 2'd1,
    DWELL      = 2'd2,
    SERVICE_ST = 2'd3
  } fsm_t;

  // Vehicle rotation SUD -> EST -> VEST -> NORD -> SUD; anything else restarts at SUD.
  function automatic light_t next_dir(input light_t dir);
    case (dir)
      SUD:     return EST;
      EST:     return VEST;
      VEST:    return NORD;
      default: return SUD;
    endcase
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// 8-bit load / decrement-on-tick counter. done is a combinational pulse on the tick
// that takes the count from 1 to 0; the count saturates at 0.
module dwell_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic       tick,
  output logic [7:0] count,
  output logic       done
);

  logic [7:0] count_reg;
  logic [7:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (en && tick && (count_reg != 8'd0)) begin
      count_next = count_reg - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign done  = !load && en && tick && (count_reg == 8'd1);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Drives the semaphore light module: issues phases, waits for ready_S, times each dwell
// on the seconds tick, inserts pedestrian phases and handles service / fault.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter logic [7:0] GREEN_T       = 8'd20,
  parameter logic [7:0] PED_T         = 8'd15,
  parameter logic [7:0] READY_TIMEOUT = 8'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ready_S,
  input  logic       ped_req,
  input  logic       service_en,
  output logic [2:0] stare_semafor,
  output logic       phase_valid,
  output logic       ped_ack,
  output logic       fault,
  output logic [7:0] seconds_left
);

  fsm_t   state_reg, state_next;
  light_t stare_reg, stare_next;
  light_t next_vehicle_reg, next_vehicle_next;
  logic   phase_valid_reg, phase_valid_next;
  logic   ped_ack_reg, ped_ack_next;
  logic   fault_reg, fault_next;
  logic   ped_pending_reg, ped_pending_next;

  logic       dwell_load;
  logic [7:0] dwell_val;
  logic [7:0] dwell_count;
  logic       dwell_done;
  logic       to_load;
  logic [7:0] to_count;
  logic       to_done;
  logic       issuing_ped;

  dwell_timer u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .load_val (dwell_val),
    .en       (state_reg == DWELL),
    .tick     (tick),
    .count    (dwell_count),
    .done     (dwell_done)
  );

  dwell_timer u_ready_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (READY_TIMEOUT),
    .en       (state_reg == WAIT_READY),
    .tick     (tick),
    .count    (to_count),
    .done     (to_done)
  );

  assign issuing_ped = (state_reg == ISSUE) && ped_pending_reg;

  always_comb begin
    state_next        = state_reg;
    stare_next        = stare_reg;
    next_vehicle_next = next_vehicle_reg;
    phase_valid_next  = 1'b0;
    ped_ack_next      = 1'b0;
    fault_next        = fault_reg;
    ped_pending_next  = ped_pending_reg;
    dwell_load        = 1'b0;
    dwell_val         = GREEN_T;
    to_load           = 1'b0;

    // Requests collapse into one flag; a walk phase never queues a second one behind it.
    if (ped_req && (stare_reg != PIETONI) && !issuing_ped) begin
      ped_pending_next = 1'b1;
    end

    if (service_en && (state_reg != SERVICE_ST)) begin
      state_next       = SERVICE_ST;
      stare_next       = SERVICE;
      phase_valid_next = 1'b1;
    end else begin
      case (state_reg)
        ISSUE: begin
          phase_valid_next = 1'b1;
          to_load          = 1'b1;
          state_next       = WAIT_READY;
          if (ped_pending_reg) begin
            stare_next       = PIETONI;
            ped_ack_next     = 1'b1;
            ped_pending_next = 1'b0;
          end else begin
            stare_next        = next_vehicle_reg;
            next_vehicle_next = next_dir(next_vehicle_reg);
          end
        end
        WAIT_READY: begin
          if (ready_S) begin
            state_next = DWELL;
            dwell_load = 1'b1;
            dwell_val  = (stare_reg == PIETONI) ? PED_T : GREEN_T;
          end else if (to_done || (to_count == 8'd0)) begin
            // A zero count here only happens with a zero timeout: fault at once.
            fault_next       = 1'b1;
            state_next       = SERVICE_ST;
            stare_next       = SERVICE;
            phase_valid_next = 1'b1;
          end
        end
        DWELL: begin
          if (dwell_done || (dwell_count == 8'd0)) begin
            state_next = ISSUE;
          end
        end
        SERVICE_ST: begin
          if (!fault_reg && !service_en) begin
            state_next        = ISSUE;
            next_vehicle_next = SUD;
          end
        end
        default: begin
          state_next = ISSUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ISSUE;
      stare_reg        <= SERVICE;
      next_vehicle_reg <= SUD;
      phase_valid_reg  <= 1'b0;
      ped_ack_reg      <= 1'b0;
      fault_reg        <= 1'b0;
      ped_pending_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      stare_reg        <= stare_next;
      next_vehicle_reg <= next_vehicle_next;
      phase_valid_reg  <= phase_valid_next;
      ped_ack_reg      <= ped_ack_next;
      fault_reg        <= fault_next;
      ped_pending_reg  <= ped_pending_next;
    end
  end

  assign stare_semafor = stare_reg;
  assign phase_valid   = phase_valid_reg;
  assign ped_ack       = ped_ack_reg;
  assign fault         = fault_reg;
  assign seconds_left  = (state_reg == DWELL) ? dwell_count : 8'd0;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler: expected phases are queued by the
// stimulus, a negedge monitor pops and checks every phase_valid and every dwell tick.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] L_SUD  = 3'b000;
  localparam logic [2:0] L_EST  = 3'b001;
  localparam logic [2:0] L_VEST = 3'b010;
  localparam logic [2:0] L_NORD = 3'b011;
  localparam logic [2:0] L_PIE  = 3'b100;
  localparam logic [2:0] L_SERV = 3'b111;

  typedef struct packed {
    logic [2:0] st;
    logic       ack;
    logic [7:0] dwell;
    logic       chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       ready_S = 1'b1;
  logic       ped_req = 1'b0;
  logic       service_en = 1'b0;
  logic [2:0] stare_semafor;
  logic       phase_valid;
  logic       ped_ack;
  logic       fault;
  logic [7:0] seconds_left;

  int   checks = 0;
  int   errors = 0;
  int   phase_cnt = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  logic [7:0] ticks = 8'd0;

  intersection_phase_scheduler #(
    .GREEN_T       (8'd4),
    .PED_T         (8'd3),
    .READY_TIMEOUT (8'd5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .ready_S       (ready_S),
    .ped_req       (ped_req),
    .service_en    (service_en),
    .stare_semafor (stare_semafor),
    .phase_valid   (phase_valid),
    .ped_ack       (ped_ack),
    .fault         (fault),
    .seconds_left  (seconds_left)
  );

  always #5 clk = ~clk;

  // One-clock tick every 8 clocks.
  initial begin
    int tdiv = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tdiv == 7);
      tdiv = (tdiv == 7) ? 0 : tdiv + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic ack, input logic [7:0] dw, input logic chk);
    exp_t e;
    e.st = st; e.ack = ack; e.dwell = dw; e.chk = chk;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stare"}, {5'd0, stare_semafor}, {5'd0, L_SERV});
    check({tag, "_phase_valid"}, {7'd0, phase_valid}, 8'd0);
    check({tag, "_ped_ack"}, {7'd0, ped_ack}, 8'd0);
    check({tag, "_fault"}, {7'd0, fault}, 8'd0);
    check({tag, "_seconds_left"}, seconds_left, 8'd0);
  endtask

  task automatic wait_phases(input int target);
    int n = 0;
    while (phase_cnt < target && n < 800) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (phase_cnt < target) begin
      errors++;
      $display("FAIL wait_phases actual=%0d required=%0d", phase_cnt, target);
    end
  endtask

  task automatic wait_state(input logic [2:0] ph, input logic [7:0] sl, input bit need_tick);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 400) begin
      @(negedge clk);
      n++;
      hit = (stare_semafor == ph) && (seconds_left == sl) && (!need_tick || tick);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_state phase=%0d seconds_left=%0d not reached", ph, sl);
    end
  endtask

  task automatic pulse_ped();
    @(posedge clk); #1 ped_req = 1'b1;
    @(posedge clk); #1 ped_req = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      have_cur = 0;
    end else begin
      if (phase_valid) begin
        if (have_cur && cur.chk) check("dwell_ticks", ticks, cur.dwell);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_phase actual=%0d required=none", stare_semafor);
          have_cur = 0;
        end else begin
          cur = exp_q.pop_front();
          check("phase", {5'd0, stare_semafor}, {5'd0, cur.st});
          check("ped_ack", {7'd0, ped_ack}, {7'd0, cur.ack});
          $display("phase %0d: stare=%0d ped_ack=%0b fault=%0b", phase_cnt, stare_semafor, ped_ack, fault);
          ticks = 8'd0;
          have_cur = 1;
        end
        phase_cnt++;
      end else if (ped_ack) begin
        checks++;
        errors++;
        $display("FAIL stray_ped_ack actual=1 required=0");
      end
      if (tick && (seconds_left != 8'd0) && have_cur) begin
        check("seconds_left", seconds_left, cur.dwell - ticks);
        ticks = ticks + 8'd1;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // 1: plain rotation
    push(L_SUD, 0, 4, 1); push(L_EST, 0, 4, 1); push(L_VEST, 0, 4, 1);
    push(L_NORD, 0, 4, 1); push(L_SUD, 0, 4, 1);
    @(posedge clk); #1 rst = 1'b1;
    wait_phases(5);

    // 2: request during EST dwell, second request during PIETONI ignored
    push(L_EST, 0, 4, 1); push(L_PIE, 1, 3, 1); push(L_VEST, 0, 4, 1);
    push(L_NORD, 0, 4, 1); push(L_SUD, 0, 4, 1); push(L_EST, 0, 4, 1);
    wait_phases(6);
    wait_state(L_EST, 8'd3, 0);
    pulse_ped();
    wait_phases(7);
    wait_state(L_PIE, 8'd2, 0);
    pulse_ped();
    wait_phases(11);

    // 3: request in the ISSUE cycle of VEST stays pending for the next boundary
    push(L_VEST, 0, 4, 1); push(L_PIE, 1, 3, 1); push(L_NORD, 0, 4, 0);
    wait_state(L_EST, 8'd1, 1);
    pulse_ped();
    wait_phases(14);

    // 4: service during NORD dwell, exit restarts at SUD
    push(L_SERV, 0, 0, 1); push(L_SUD, 0, 4, 1);
    wait_state(L_NORD, 8'd2, 0);
    @(posedge clk); #1 service_en = 1'b1;
    wait_phases(15);
    repeat (40) @(negedge clk);
    check("service_stare", {5'd0, stare_semafor}, {5'd0, L_SERV});
    check("service_seconds_left", seconds_left, 8'd0);
    @(posedge clk); #1 service_en = 1'b0;
    wait_phases(16);

    // 5: ready_S timeout -> sticky fault
    push(L_EST, 0, 0, 1); push(L_SERV, 0, 0, 0);
    wait_state(L_SUD, 8'd2, 0);
    @(posedge clk); #1 ready_S = 1'b0;
    wait_phases(18);
    @(negedge clk);
    check("fault_set", {7'd0, fault}, 8'd1);
    @(posedge clk); #1 service_en = 1'b1;
    repeat (20) @(posedge clk);
    #1 service_en = 1'b0;
    repeat (30) @(negedge clk);
    check("fault_stare", {5'd0, stare_semafor}, {5'd0, L_SERV});
    check("fault_sticky", {7'd0, fault}, 8'd1);
    check("fault_no_phase", phase_cnt[7:0], 8'd18);
    @(posedge clk); #1 rst = 1'b0;
    #2 check_reset_vals("fault_rst");
    @(posedge clk); #1 ready_S = 1'b1; rst = 1'b1;
    push(L_SUD, 0, 4, 1);
    wait_phases(19);

    // 6: reset during WAIT_READY drops the pending request
    push(L_EST, 0, 0, 0);
    wait_state(L_SUD, 8'd2, 0);
    @(posedge clk); #1 ready_S = 1'b0;
    wait_phases(20);
    repeat (2) @(posedge clk);
    pulse_ped();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 check_reset_vals("mid_rst");
    push(L_SUD, 0, 4, 1); push(L_EST, 0, 4, 1); push(L_VEST, 0, 4, 0);
    @(posedge clk); #1 ready_S = 1'b1; rst = 1'b1;
    wait_phases(23);

    check("queue_empty", exp_q.size() > 255 ? 8'd255 : 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
